// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port memory,
// one outstanding transaction at a time, data first with a fetch starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic                    imem_read,
  output logic [DATA_WIDTH-1:0]   imem_data,
  output logic                    imem_ready,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_data_out,
  input  logic                    dmem_read,
  input  logic                    dmem_write,
  input  logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
  output logic [DATA_WIDTH-1:0]   dmem_data_in,
  output logic                    dmem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    bus_error
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int SW   = $clog2(MAX_D_STREAK + 1);
  localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SW'(MAX_D_STREAK)) ? v : v + SW'(1);
  endfunction

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]       mem_be_q, mem_be_d;
  logic                  imem_ready_q, imem_ready_d;
  logic                  dmem_ready_q, dmem_ready_d;
  logic                  bus_error_q, bus_error_d;
  logic [DATA_WIDTH-1:0] imem_data_q, imem_data_d;
  logic [DATA_WIDTH-1:0] dmem_data_in_q, dmem_data_in_d;

  logic                  d_pend, i_pend, d_wins, expired;
  logic                  finish, load;
  logic [DATA_WIDTH-1:0] load_val;

  assign d_pend  = dmem_read | dmem_write;
  assign i_pend  = imem_read;
  assign d_wins  = d_pend && (!i_pend || (streak_q < SW'(MAX_D_STREAK)));
  assign expired = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    streak_d       = streak_q;
    tcnt_d         = tcnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    imem_ready_d   = 1'b0;
    dmem_ready_d   = 1'b0;
    bus_error_d    = 1'b0;
    imem_data_d    = imem_data_q;
    dmem_data_in_d = dmem_data_in_q;
    finish         = 1'b0;
    load           = 1'b0;
    load_val       = '0;

    case (state_q)
      ARB_IDLE: begin
        if (d_wins || i_pend) begin
          state_d     = ARB_REQ;
          mem_req_d   = 1'b1;
          tcnt_d      = '0;
          owner_d     = d_wins ? ARB_OWNER_D : ARB_OWNER_I;
          // A simultaneous read+write request is carried out as a write only.
          mem_we_d    = d_wins && dmem_write;
          mem_addr_d  = d_wins ? dmem_addr : imem_addr;
          mem_wdata_d = dmem_data_out;
          mem_be_d    = (d_wins && dmem_write) ? dmem_byte_enable : '1;
          streak_d    = (d_wins && i_pend) ? sat_inc(streak_q) : '0;
        end
      end
      ARB_REQ: begin
        tcnt_d = tcnt_q + TW'(1);
        if (mem_ack) begin
          if (mem_we_q) begin
            finish = 1'b1;
          end else if (mem_rvalid) begin
            finish   = 1'b1;
            load     = 1'b1;
            load_val = mem_rdata;
          end else begin
            state_d   = ARB_WAIT;
            mem_req_d = 1'b0;
          end
        end else if (expired) begin
          finish      = 1'b1;
          load        = 1'b1;
          bus_error_d = 1'b1;
        end
      end
      ARB_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (mem_rvalid) begin
          finish   = 1'b1;
          load     = 1'b1;
          load_val = mem_rdata;
        end else if (expired) begin
          finish      = 1'b1;
          load        = 1'b1;
          bus_error_d = 1'b1;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    // Completion (normal or aborted) always returns the ready pulse to the owner.
    if (finish) begin
      state_d   = ARB_DONE;
      mem_req_d = 1'b0;
      if (owner_q == ARB_OWNER_D) begin
        dmem_ready_d = 1'b1;
        if (load) dmem_data_in_d = load_val;
      end else begin
        imem_ready_d = 1'b1;
        if (load) imem_data_d = load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      owner_q        <= ARB_OWNER_I;
      streak_q       <= '0;
      tcnt_q         <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      imem_ready_q   <= 1'b0;
      dmem_ready_q   <= 1'b0;
      bus_error_q    <= 1'b0;
      imem_data_q    <= '0;
      dmem_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      streak_q       <= streak_d;
      tcnt_q         <= tcnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      imem_ready_q   <= imem_ready_d;
      dmem_ready_q   <= dmem_ready_d;
      bus_error_q    <= bus_error_d;
      imem_data_q    <= imem_data_d;
      dmem_data_in_q <= dmem_data_in_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign imem_ready   = imem_ready_q;
  assign dmem_ready   = dmem_ready_q;
  assign bus_error    = bus_error_q;
  assign imem_data    = imem_data_q;
  assign dmem_data_in = dmem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized transaction-level run for mem_arbiter.
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data;
  logic        imem_read, imem_ready;
  logic [31:0] dmem_addr, dmem_data_out, dmem_data_in;
  logic        dmem_read, dmem_write, dmem_ready;
  logic [3:0]  dmem_byte_enable;
  logic        mem_req, mem_we, mem_ack, mem_rvalid, bus_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_D_STREAK(MAXS), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_read(imem_read), .imem_data(imem_data), .imem_ready(imem_ready),
    .dmem_addr(dmem_addr), .dmem_data_out(dmem_data_out), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_data_in(dmem_data_in), .dmem_ready(dmem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_error(bus_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference-model state for the randomized run
  bit          i_pend, d_pend, d_we, cur_d, cur_we, resp_prev;
  logic [31:0] i_addr, d_addr, d_wdata, cur_rdata, last_i, last_d;
  logic [3:0]  d_be;
  int          streak_m, mst, ack_cnt, rv_cnt, idle_wait, kind;
  int          grants, c, last_grant_c;
  bit          win;

  initial begin
    reset = 1'b1;
    imem_addr = '0; imem_read = 0;
    dmem_addr = '0; dmem_data_out = '0; dmem_read = 0; dmem_write = 0; dmem_byte_enable = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();

    // reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_iready", imem_ready, 0);
    check("rst_dready", dmem_ready, 0);
    check("rst_berr", bus_error, 0);
    check("rst_idata", imem_data, 0);
    check("rst_ddata", dmem_data_in, 0);
    reset = 1'b0;
    tick();

    // fetch only, zero-wait memory
    imem_read = 1; imem_addr = 32'h100;
    tick();
    check("f_req", mem_req, 1);
    check("f_addr", mem_addr, 32'h100);
    check("f_be", mem_be, 4'hF);
    check("f_we", mem_we, 0);
    check("f_iready_early", imem_ready, 0);
    mem_ack = 1; mem_rvalid = 1; mem_rdata = 32'h00500093;
    tick();
    check("f_iready", imem_ready, 1);
    check("f_idata", imem_data, 32'h00500093);
    check("f_dready", dmem_ready, 0);
    check("f_req_drop", mem_req, 0);
    mem_ack = 0; mem_rvalid = 0; imem_read = 0;
    tick();
    check("f_iready_once", imem_ready, 0);
    tick();
    check("f_idle", mem_req, 0);

    // store held for three cycles before ack
    dmem_write = 1; dmem_addr = 32'h2004; dmem_data_out = 32'hDEADBEEF; dmem_byte_enable = 4'b0011;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("st_req", mem_req, 1);
      check("st_we", mem_we, 1);
      check("st_addr", mem_addr, 32'h2004);
      check("st_wdata", mem_wdata, 32'hDEADBEEF);
      check("st_be", mem_be, 4'b0011);
      check("st_dready_early", dmem_ready, 0);
      if (k == 2) mem_ack = 1;
      tick();
    end
    check("st_dready", dmem_ready, 1);
    check("st_iready", imem_ready, 0);
    check("st_ddata_kept", dmem_data_in, 0);
    mem_ack = 0; dmem_write = 0;
    tick();
    check("st_dready_once", dmem_ready, 0);
    check("st_iready_after", imem_ready, 0);

    // contention: both held, zero-wait memory
    imem_read = 1; imem_addr = 32'h400; dmem_read = 1; dmem_addr = 32'h800;
    grants = 0; c = 0; last_grant_c = 0;
    while (grants < 10 && c < 40) begin
      tick(); c++;
      mem_ack = 0; mem_rvalid = 0;
      if (mem_req) begin
        check("cont_owner_is_d", (mem_addr == 32'h800), ((grants % 5) != 4));
        grants++;
        last_grant_c = c;
        mem_ack = 1; mem_rvalid = 1; mem_rdata = $urandom;
      end
    end
    check("cont_grants", grants, 10);
    check("cont_rate", last_grant_c, 28);
    tick();
    mem_ack = 0; mem_rvalid = 0; imem_read = 0; dmem_read = 0;
    tick(); tick();

    // split read: ack first, rvalid five cycles later
    dmem_read = 1; dmem_addr = 32'h3000;
    tick();
    check("sp_req", mem_req, 1);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      check("sp_req_low", mem_req, 0);
      check("sp_dready_early", dmem_ready, 0);
      tick();
    end
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 0; dmem_read = 0;
    check("sp_dready", dmem_ready, 1);
    check("sp_ddata", dmem_data_in, 32'h12345678);
    tick();
    check("sp_dready_once", dmem_ready, 0);

    // timeout: no ack ever
    dmem_read = 1; dmem_addr = 32'h4000;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("to_req", mem_req, 1);
      check("to_dready_early", dmem_ready, 0);
      tick();
    end
    check("to_dready", dmem_ready, 1);
    check("to_berr", bus_error, 1);
    check("to_data", dmem_data_in, 0);
    check("to_req_drop", mem_req, 0);
    dmem_read = 0; mem_rvalid = 1; mem_ack = 1; mem_rdata = 32'hAAAA5555;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("to_stray_dready", dmem_ready, 0);
      check("to_stray_berr", bus_error, 0);
      check("to_stray_data", dmem_data_in, 0);
      check("to_stray_req", mem_req, 0);
    end
    mem_rvalid = 0; mem_ack = 0;
    tick();

    // reset asserted in WAIT
    dmem_read = 1; dmem_addr = 32'h5000;
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    reset = 1;
    tick();
    check("rw_req", mem_req, 0);
    check("rw_dready", dmem_ready, 0);
    check("rw_iready", imem_ready, 0);
    check("rw_addr", mem_addr, 0);
    reset = 0; dmem_read = 0; mem_rvalid = 1; mem_rdata = 32'h99;
    tick();
    mem_rvalid = 0;
    check("rw_stray_dready", dmem_ready, 0);
    tick();
    check("rw_stray_dready2", dmem_ready, 0);
    check("rw_stray_data", dmem_data_in, 0);
    imem_read = 1; imem_addr = 32'h600;
    tick();
    check("rw_f_req", mem_req, 1);
    check("rw_f_addr", mem_addr, 32'h600);
    mem_ack = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    tick();
    check("rw_f_iready", imem_ready, 1);
    check("rw_f_idata", imem_data, 32'h77);
    mem_ack = 0; mem_rvalid = 0; imem_read = 0;
    tick();

    // randomized run against a transaction-level model
    reset = 1; tick(); tick(); reset = 0;
    i_pend = 0; d_pend = 0; d_we = 0; streak_m = 0; mst = 0; resp_prev = 0; idle_wait = 0;
    last_i = '0; last_d = '0; cur_d = 0; cur_we = 0; cur_rdata = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      mem_ack = 0; mem_rvalid = 0;
      check("rnd_iready", imem_ready, resp_prev && !cur_d);
      check("rnd_dready", dmem_ready, resp_prev && cur_d);
      if (resp_prev) begin
        check("rnd_berr", bus_error, 0);
        check("rnd_req_done", mem_req, 0);
        if (cur_d) begin
          if (!cur_we) last_d = cur_rdata;
          check("rnd_ddata", dmem_data_in, last_d);
          d_pend = 0; dmem_read = 0; dmem_write = 0;
        end else begin
          last_i = cur_rdata;
          check("rnd_idata", imem_data, last_i);
          i_pend = 0; imem_read = 0;
        end
        resp_prev = 0; mst = 0;
      end else if (mst == 0 && mem_req) begin
        win = d_pend && (!i_pend || streak_m < MAXS);
        cur_d = win;
        cur_we = win && d_we;
        check("rnd_addr", mem_addr, win ? d_addr : i_addr);
        check("rnd_we", mem_we, cur_we);
        check("rnd_be", mem_be, cur_we ? d_be : 4'hF);
        if (cur_we) check("rnd_wdata", mem_wdata, d_wdata);
        streak_m = (win && i_pend) ? ((streak_m + 1 > MAXS) ? MAXS : streak_m + 1) : 0;
        mst = 1; ack_cnt = $urandom_range(0, 2); idle_wait = 0;
      end else if (mst == 0 && (i_pend || d_pend)) begin
        idle_wait++;
        check("rnd_grant_latency_ok", (idle_wait <= 3), 1);
      end

      if (mst == 1) begin
        check("rnd_req_held", mem_req, 1);
        if (ack_cnt == 0) begin
          mem_ack = 1;
          if (cur_we) begin
            mst = 3; resp_prev = 1;
          end else begin
            rv_cnt = $urandom_range(0, 3);
            if (rv_cnt == 0) begin
              mem_rvalid = 1; mem_rdata = $urandom; cur_rdata = mem_rdata;
              mst = 3; resp_prev = 1;
            end else mst = 2;
          end
        end else ack_cnt--;
      end else if (mst == 2) begin
        check("rnd_wait_req_low", mem_req, 0);
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = $urandom; cur_rdata = mem_rdata;
          mst = 3; resp_prev = 1;
        end
      end else if (mst == 0) begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end

      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_addr = $urandom;
        imem_read = 1; imem_addr = i_addr;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; kind = $urandom_range(0, 2);
        d_we = (kind != 0);
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
        dmem_read = (kind != 1); dmem_write = (kind != 0);
        dmem_addr = d_addr; dmem_data_out = d_wdata; dmem_byte_enable = d_be;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
